// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for the five-stage pipeline: forwarding, local
// stalls, divider/memory-wait stalls, precise (possibly deferred) exceptions, stall watchdog.
module pipe_hazard_ctrl #(
    parameter int          REG_AW    = 5,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000E,
    parameter int          CNT_W     = 16,
    parameter int          TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic              div_doneE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              regwriteW,
    input  logic              i_stall,
    input  logic              d_stall,
    input  logic [31:0]       excepttypeM,
    input  logic [31:0]       epcM,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic [31:0]       newpcM,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, EXC_PEND} state_t;

    state_t             state, stateNext;
    logic [31:0]        pendType, pendEpc, newpcReg;
    logic [31:0]        takenType, takenEpc, excPc;
    logic               exc, excTaken;
    logic               lwStall, brHaz, brStall, jrStall, divStall;
    logic [CNT_W-1:0]   cntNext;

    // Forwarding: M result has priority over W
    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    always_comb begin
        forwardaE = 2'b00;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM) forwardaE = 2'b10;
        else if ((rsE == writeregW) && regwriteW)           forwardaE = 2'b01;
        forwardbE = 2'b00;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM) forwardbE = 2'b10;
        else if ((rtE == writeregW) && regwriteW)           forwardbE = 2'b01;
    end

    assign lwStall  = memtoregE && ((rtE == rsD) || (rtE == rtD));
    assign brHaz    = (regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                      (memtoregM && ((writeregM == rsD) || (writeregM == rtD)));
    assign brStall  = branchD && brHaz;
    assign jrStall  = jrD && brHaz;
    assign divStall = divE && !div_doneE;

    assign exc = (excepttypeM != '0);

    always_comb begin
        stateNext = state;
        case (state)
            RUN:      if (d_stall) stateNext = exc ? EXC_PEND : MEM_WAIT;
            MEM_WAIT: if (!d_stall) stateNext = RUN;
                      else if (exc) stateNext = EXC_PEND;
            EXC_PEND: if (!d_stall) stateNext = RUN;
            default:  stateNext = RUN;
        endcase
    end

    // A pending exception is only ever taken from the values latched on entry
    assign excTaken  = !rst && !d_stall && ((state == EXC_PEND) || exc);
    assign takenType = (state == EXC_PEND) ? pendType : excepttypeM;
    assign takenEpc  = (state == EXC_PEND) ? pendEpc  : epcM;
    assign excPc     = (takenType == ERET_CODE) ? takenEpc : EXC_VEC;
    assign newpcM    = excTaken ? excPc : newpcReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pendType <= '0;
            pendEpc  <= '0;
            newpcReg <= '0;
        end else begin
            state <= stateNext;
            if (stateNext == EXC_PEND && state != EXC_PEND) begin
                pendType <= excepttypeM;
                pendEpc  <= epcM;
            end
            if (excTaken) newpcReg <= excPc;
        end
    end

    always_comb begin
        {stallF, stallD, stallE, stallM}         = '0;
        {flushF, flushD, flushE, flushM, flushW} = '0;
        if (rst) begin
            {flushF, flushD, flushE, flushM, flushW} = '1;
        end else if (excTaken) begin
            {flushF, flushD, flushE, flushM, flushW} = '1;
        end else if (d_stall) begin
            {stallF, stallD, stallE, stallM} = '1;
            flushW = 1'b1;
        end else if (divStall) begin
            {stallF, stallD, stallE} = '1;
            flushM = 1'b1;
        end else if (lwStall || brStall || jrStall) begin
            {stallF, stallD} = '1;
            flushE = 1'b1;
        end else if (i_stall) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

    assign cntNext = !stallF ? '0 : ((stall_cycles == '1) ? stall_cycles : stall_cycles + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cycles <= cntNext;
            if (cntNext == CNT_W'(TIMEOUT)) stall_timeout <= 1'b1;
        end
    end
endmodule
